// File: rtl/core_bp_track.sv
// In-order tracking queue for in-flight conditional branches: captures the IF-stage
// prediction context and emits a registered PHT update bundle when EX resolves the oldest entry.
module core_bp_track #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2,
    parameter int unsigned PC_W  = 6,
    parameter int unsigned BHR_W = 4,
    parameter int unsigned PHT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [PC_W-1:0]  push_pc,
    input  logic [BHR_W-1:0] push_bhr,
    input  logic [PHT_W-1:0] push_pht,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count,
    output logic             update_BP,
    output logic             pred_right,
    output logic             taken,
    output logic [BHR_W-1:0] BHR_in,
    output logic [PHT_W-1:0] delayed_PHT,
    output logic [PC_W-1:0]  id_pc,
    output logic             mispredict,
    output logic             overflow
);

    logic [PC_W-1:0]  pc_mem_q  [DEPTH];
    logic [BHR_W-1:0] bhr_mem_q [DEPTH];
    logic [PHT_W-1:0] pht_mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             upd_q, upd_d, pr_q, pr_d, tk_q, tk_d, mis_q, mis_d, ovf_q, ovf_d;
    logic [BHR_W-1:0] bhr_q, bhr_d;
    logic [PHT_W-1:0] pht_q, pht_d;
    logic [PC_W-1:0]  pc_q, pc_d;

    logic pop, pred_ok, mis, clear, push_acc;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    always_comb begin
        pop      = res_valid && !empty;
        pred_ok  = (pht_mem_q[head_q][PHT_W-1] == res_taken);
        mis      = pop && !pred_ok;
        // A mispredicted pop or an external flush kills every younger entry, including a same-cycle push.
        clear    = flush || mis;
        push_acc = push && (!full || pop) && !clear;

        head_d  = clear ? '0 : head_q + PTR_W'(pop);
        tail_d  = clear ? '0 : tail_q + PTR_W'(push_acc);
        count_d = clear ? '0 : count_q + (PTR_W+1)'(push_acc) - (PTR_W+1)'(pop);
        ovf_d   = ovf_q | (push & full & ~pop);

        upd_d = pop;
        mis_d = mis;
        pr_d  = pr_q;
        tk_d  = tk_q;
        bhr_d = bhr_q;
        pht_d = pht_q;
        pc_d  = pc_q;
        if (pop) begin
            pr_d  = pred_ok;
            tk_d  = res_taken;
            bhr_d = bhr_mem_q[head_q];
            pht_d = pht_mem_q[head_q];
            pc_d  = pc_mem_q[head_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            upd_q   <= 1'b0;
            pr_q    <= 1'b0;
            tk_q    <= 1'b0;
            mis_q   <= 1'b0;
            ovf_q   <= 1'b0;
            bhr_q   <= '0;
            pht_q   <= '0;
            pc_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            upd_q   <= upd_d;
            pr_q    <= pr_d;
            tk_q    <= tk_d;
            mis_q   <= mis_d;
            ovf_q   <= ovf_d;
            bhr_q   <= bhr_d;
            pht_q   <= pht_d;
            pc_q    <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_acc) begin
            pc_mem_q[tail_q]  <= push_pc;
            bhr_mem_q[tail_q] <= push_bhr;
            pht_mem_q[tail_q] <= push_pht;
        end
    end

    assign update_BP   = upd_q;
    assign pred_right  = pr_q;
    assign taken       = tk_q;
    assign BHR_in      = bhr_q;
    assign delayed_PHT = pht_q;
    assign id_pc       = pc_q;
    assign mispredict  = mis_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_core_bp_track.sv
// Directed bench for core_bp_track: queue-based reference model checked every cycle,
// plus literal expectations from the worked scenarios.
module tb_core_bp_track;

    logic       clk = 1'b0;
    logic       rst, push, res_valid, res_taken, flush;
    logic [5:0] push_pc;
    logic [3:0] push_bhr;
    logic [1:0] push_pht;
    logic       full, empty, update_BP, pred_right, taken, mispredict, overflow;
    logic [2:0] count;
    logic [3:0] BHR_in;
    logic [1:0] delayed_PHT;
    logic [5:0] id_pc;

    core_bp_track #(.DEPTH(4), .PTR_W(2), .PC_W(6), .BHR_W(4), .PHT_W(2)) dut (
        .clk(clk), .rst(rst), .push(push), .push_pc(push_pc), .push_bhr(push_bhr),
        .push_pht(push_pht), .res_valid(res_valid), .res_taken(res_taken), .flush(flush),
        .full(full), .empty(empty), .count(count), .update_BP(update_BP),
        .pred_right(pred_right), .taken(taken), .BHR_in(BHR_in), .delayed_PHT(delayed_PHT),
        .id_pc(id_pc), .mispredict(mispredict), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] pc;
        logic [3:0] bhr;
        logic [1:0] pht;
    } ent_t;

    ent_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   chk_en = 1'b0;

    logic       m_upd, m_pr, m_tk, m_mis, m_ovf;
    logic [3:0] m_bhr;
    logic [1:0] m_pht;
    logic [5:0] m_pc;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock with the given inputs and update the reference model from the same inputs.
    task automatic step(input bit r, input bit p, input logic [5:0] pc, input logic [3:0] bhr,
                        input logic [1:0] pht, input bit rv, input bit rt, input bit fl);
        bit   do_pop, kill, was_full;
        ent_t e;
        rst = r; push = p; push_pc = pc; push_bhr = bhr; push_pht = pht;
        res_valid = rv; res_taken = rt; flush = fl;
        @(posedge clk);
        if (r) begin
            q.delete();
            {m_upd, m_pr, m_tk, m_mis, m_ovf} = '0;
            m_bhr = '0; m_pht = '0; m_pc = '0;
        end else begin
            do_pop   = rv && (q.size() > 0);
            was_full = (q.size() == 4);
            m_upd = do_pop;
            m_mis = 1'b0;
            if (do_pop) begin
                e     = q[0];
                m_tk  = rt;
                m_pr  = (e.pht[1] == rt);
                m_mis = !m_pr;
                m_bhr = e.bhr; m_pht = e.pht; m_pc = e.pc;
            end
            if (p && was_full && !do_pop) m_ovf = 1'b1;
            kill = fl || m_mis;
            if (kill) q.delete();
            else begin
                if (do_pop) void'(q.pop_front());
                if (p && (!was_full || do_pop)) q.push_back('{pc: pc, bhr: bhr, pht: pht});
            end
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", count, q.size());
            chk("full", full, q.size() == 4);
            chk("empty", empty, q.size() == 0);
            chk("update_BP", update_BP, m_upd);
            chk("mispredict", mispredict, m_mis);
            chk("overflow", overflow, m_ovf);
            chk("pred_right", pred_right, m_pr);
            chk("taken", taken, m_tk);
            chk("BHR_in", BHR_in, m_bhr);
            chk("delayed_PHT", delayed_PHT, m_pht);
            chk("id_pc", id_pc, m_pc);
        end
    end

    initial begin
        // 1: reset, fill, overflow
        step(1, 1, 6'h3F, 4'hF, 2'b11, 1, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        for (int i = 1; i <= 4; i++) step(0, 1, 6'(i), 4'h3, 2'b10, 0, 0, 0);
        chk("fill_count", count, 4);
        chk("fill_full", full, 1);
        chk("fill_ovf", overflow, 0);
        step(0, 1, 6'h09, 4'h3, 2'b10, 0, 0, 0);
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 4);

        // 2: single correct prediction
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 6'h05, 4'hA, 2'b11, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        chk("t2_upd", update_BP, 1);
        chk("t2_pr", pred_right, 1);
        chk("t2_tk", taken, 1);
        chk("t2_bhr", BHR_in, 4'hA);
        chk("t2_pht", delayed_PHT, 2'b11);
        chk("t2_pc", id_pc, 6'h05);
        chk("t2_mis", mispredict, 0);
        chk("t2_empty", empty, 1);
        idle();
        chk("t2_upd_drop", update_BP, 0);

        // 3: mispredict flushes younger entries
        step(0, 1, 6'h07, 4'h1, 2'b01, 0, 0, 0);
        step(0, 1, 6'h08, 4'h2, 2'b10, 0, 0, 0);
        step(0, 1, 6'h09, 4'h3, 2'b10, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        chk("t3_pr", pred_right, 0);
        chk("t3_mis", mispredict, 1);
        chk("t3_count", count, 0);
        chk("t3_pc", id_pc, 6'h07);
        idle();
        chk("t3_mis_pulse", mispredict, 0);

        // 4: full queue, simultaneous push/pop over 3 rotations
        for (int i = 0; i < 4; i++) step(0, 1, 6'(8 + i), 4'(i), 2'b11, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 6'(12 + i), 4'(i + 4), 2'b11, 1, 1, 0);
            if (i == 3) chk("t4_4th_pc", id_pc, 6'h0B);
            if (i == 4) chk("t4_new_pc", id_pc, 6'h0C);
        end
        chk("t4_count", count, 4);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 1, 0);
        chk("t4_last_pc", id_pc, 6'h17);

        // 5: resolve on empty
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk("t5_upd", update_BP, 0);
        chk("t5_count", count, 0);

        // 6: flush with same-cycle pop and push, then mid-stream reset
        step(0, 1, 6'h14, 4'h4, 2'b11, 0, 0, 0);
        step(0, 1, 6'h15, 4'h5, 2'b11, 0, 0, 0);
        step(0, 1, 6'h16, 4'h6, 2'b11, 1, 1, 1);
        chk("t6_upd", update_BP, 1);
        chk("t6_pc", id_pc, 6'h14);
        chk("t6_count", count, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        chk("t6_absent", update_BP, 0);
        step(0, 1, 6'h21, 4'h7, 2'b10, 0, 0, 0);
        step(0, 1, 6'h22, 4'h8, 2'b00, 1, 1, 0);
        step(1, 1, 6'h23, 4'h9, 2'b01, 1, 0, 0);
        chk("t6_rst_upd", update_BP, 0);
        chk("t6_rst_pc", id_pc, 0);
        chk("t6_rst_bhr", BHR_in, 0);
        chk("t6_rst_count", count, 0);
        idle();
        idle();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/core_bp_track.md
Name: core_bp_track

Overview:
In-order tracking queue for in-flight conditional branches, placed between the IF-stage predictor lookup and the EX-stage branch resolution. At IF it captures the prediction context for each branch: pc index, BHR value and PHT counter. When the branch resolves it produces the registered update bundle (update_BP, pred_right, taken, BHR, delayed PHT counter, pc index) that drives the pattern history table write port. It also flags mispredictions and flushes wrong-path entries.

Parameters:
DEPTH, 4, number of queue entries (power of two, at least 2)
PTR_W, 2, log2(DEPTH)
PC_W, 6, width of tracked pc index (pc[10:5])
BHR_W, 4, branch history register width
PHT_W, 2, saturating counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
push  in  1  IF has a conditional branch this cycle and is not stalled
push_pc  in  PC_W  pc[10:5] of the branch
push_bhr  in  BHR_W  BHR read for the branch
push_pht  in  PHT_W  PHT counter read; predicted direction = push_pht[PHT_W-1]
res_valid  in  1  EX resolves the oldest tracked branch this cycle
res_taken  in  1  actual branch direction
flush  in  1  external pipeline flush (exception/redirect)
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  PTR_W+1  occupied entries
update_BP  out  1  registered update strobe to PHT
pred_right  out  1  registered: predicted direction == actual
taken  out  1  registered actual direction
BHR_in  out  BHR_W  registered BHR of resolved branch
delayed_PHT  out  PHT_W  registered PHT counter of resolved branch
id_pc  out  PC_W  registered pc index of resolved branch
mispredict  out  1  registered one-cycle pulse, aligned with update_BP
overflow  out  1  sticky: push while full without a same-cycle pop

Behaviour:
- Reset (rst=1 at posedge): head=tail=0; count=0; all registered outputs 0; overflow=0. empty=1, full=0. Reset has priority over all other inputs and aborts any operation in progress.
- Storage is a circular buffer with head (oldest) and tail pointers. Pointers wrap modulo DEPTH. count is held as an explicit counter.
- Pop: occurs when res_valid && !empty. The head entry is read combinationally, and at the next posedge:
  - update_BP=1, taken=res_taken
  - pred_right = (entry.pht[PHT_W-1] == res_taken)
  - BHR_in, delayed_PHT and id_pc take the entry's fields
  - mispredict = !pred_right
  - head advances by 1
- Result latency: the update bundle is valid exactly 1 cycle after the resolving res_valid and lasts 1 cycle. In all other cycles update_BP=0 and mispredict=0; the data outputs hold their last values.
- res_valid while empty: ignored. No pop, no update_BP.
- Push: occurs when push && (!full || pop this cycle). Writes the entry at tail; tail advances.
  - push while full with no pop: entry dropped, overflow set (cleared only by rst).
  - Simultaneous push and pop with no flush: both happen; count is unchanged.
- Mispredict flush: if the popped entry mispredicts, every younger entry is wrong-path. At that posedge head=tail=0 and count=0, and any same-cycle push is discarded. The update for the resolved branch is still issued.
- External flush: same clearing as a mispredict flush; a same-cycle push is discarded. A same-cycle valid pop is still processed and its update is issued the next cycle (the resolving branch is older than the flush).
- Arithmetic:
  - count next = count + push_accepted − pop, saturating to 0 when flushed.
  - The pointers are PTR_W bits and wrap naturally.
- full and empty are combinational from count.

Test Plan:
1. Reset, then 4 pushes (pc=1..4, pht=2'b10, bhr=4'h3) with no resolves -> count=4, full=1, overflow=0. A 5th push -> overflow=1, count stays 4.
2. Push pc=6'h05, pht=2'b11, bhr=4'hA; next cycle res_valid with res_taken=1 -> the cycle after: update_BP=1, pred_right=1, taken=1, BHR_in=4'hA, delayed_PHT=2'b11, id_pc=6'h05, mispredict=0, empty=1.
3. Push 3 entries, the first with pht=2'b01; resolve it with res_taken=1 -> pred_right=0, mispredict=1 for one cycle; count=0, and the 2 younger entries are lost.
4. Full queue; push and pop (correct prediction) in the same cycle -> count stays 4; the new entry pops 4th in order. Pointer wrap checked over 3 full rotations.
5. res_valid on an empty queue -> update_BP stays 0 and count stays 0.
6. 2 entries; same-cycle flush, correct-prediction res_valid and push -> next cycle update_BP=1 for the old head; count=0; the pushed entry is absent. rst asserted mid-stream -> all outputs 0 the next cycle.
